// File: rtl/kgp_ctrl_pkg.sv
// rtl/kgp_ctrl_pkg.sv - opcodes, field positions, FSM state and control bundle for control_sequencer
package kgp_ctrl_pkg;

    localparam logic [5:0] OP_RALU = 6'h00;
    localparam logic [5:0] OP_LD   = 6'h10;
    localparam logic [5:0] OP_ST   = 6'h11;
    localparam logic [5:0] OP_BR   = 6'h20;
    localparam logic [5:0] OP_BZ   = 6'h21;
    localparam logic [5:0] OP_BNZ  = 6'h22;
    localparam logic [5:0] OP_BCY  = 6'h23;
    localparam logic [5:0] OP_BS   = 6'h24;
    localparam logic [5:0] OP_BV   = 6'h25;
    localparam logic [5:0] OP_JR   = 6'h30;
    localparam logic [5:0] OP_CALL = 6'h31;
    localparam logic [5:0] OP_HLT  = 6'h3F;

    localparam logic [3:0] FN_SHIFT_LO = 4'd8;
    localparam logic [3:0] FN_SHIFT_HI = 4'd11;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 26;
    localparam int RS_MSB  = 25;
    localparam int RS_LSB  = 21;
    localparam int RT_MSB  = 20;
    localparam int RT_LSB  = 16;
    localparam int SH_MSB  = 15;
    localparam int SH_LSB  = 11;
    localparam int FN_MSB  = 3;
    localparam int IMM_MSB = 20;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        COND_NONE   = 3'd0,
        COND_ALWAYS = 3'd1,
        COND_ZERO   = 3'd2,
        COND_NZERO  = 3'd3,
        COND_CARRY  = 3'd4,
        COND_SIGN   = 3'd5,
        COND_OVF    = 3'd6
    } cond_e;

    typedef struct packed {
        logic [3:0]  alu_control;
        logic        alu_src;
        logic        const_src;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        reg_data;
        logic        reg_to_pc;
        logic        write_sel;
        logic [4:0]  reg_addr_1;
        logic [4:0]  reg_addr_2;
        logic [4:0]  shift_amount;
        logic [20:0] imm;
    } ctrl_t;

    // Word offset field, sign-extended and scaled to bytes.
    function automatic logic [31:0] branch_offset(input logic [20:0] off);
        return {{9{off[20]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// rtl/ctrl_decoder.sv - combinational instruction decode into DataPath controls and branch condition
module ctrl_decoder
    import kgp_ctrl_pkg::*;
(
    input  logic [31:0] ir,
    output ctrl_t       ctrl,
    output cond_e       cond,
    output logic        is_jr,
    output logic        is_halt
);

    logic [5:0] op;
    logic [3:0] fn;
    logic       is_shift;

    assign op       = ir[OP_MSB:OP_LSB];
    assign fn       = ir[FN_MSB:0];
    assign is_shift = (fn >= FN_SHIFT_LO) && (fn <= FN_SHIFT_HI);

    always_comb begin
        ctrl              = '0;
        cond              = COND_NONE;
        is_jr             = 1'b0;
        is_halt           = 1'b0;
        ctrl.reg_addr_1   = ir[RS_MSB:RS_LSB];
        ctrl.reg_addr_2   = ir[RT_MSB:RT_LSB];
        ctrl.shift_amount = ir[SH_MSB:SH_LSB];
        ctrl.imm          = ir[IMM_MSB:0];

        if (op == OP_RALU) begin
            ctrl.alu_control = fn;
            ctrl.alu_src     = is_shift;
            ctrl.const_src   = is_shift;
            ctrl.reg_write   = 1'b1;
            ctrl.write_sel   = 1'b1;
        end else if (op[5:4] == 2'b00) begin
            ctrl.alu_control = op[3:0];
            ctrl.alu_src     = 1'b1;
            ctrl.reg_write   = 1'b1;
            ctrl.write_sel   = 1'b1;
        end else begin
            case (op)
                OP_LD: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.mem_read  = 1'b1;
                    ctrl.reg_data  = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.write_sel = 1'b1;
                end
                OP_ST: begin
                    ctrl.alu_src   = 1'b1;
                    ctrl.mem_write = 1'b1;
                end
                OP_BR:  cond = COND_ALWAYS;
                OP_BZ:  cond = COND_ZERO;
                OP_BNZ: cond = COND_NZERO;
                OP_BCY: cond = COND_CARRY;
                OP_BS:  cond = COND_SIGN;
                OP_BV:  cond = COND_OVF;
                OP_JR:  is_jr = 1'b1;
                OP_CALL: begin
                    cond           = COND_ALWAYS;
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_to_pc = 1'b1;
                end
                OP_HLT: is_halt = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/exec/update sequencer owning the PC; CTRL_RETIRE_CNT_EN adds retire_count
module control_sequencer
    import kgp_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        zero_flag,
    input  logic        carry_flag,
    input  logic        sign_flag,
    input  logic        overflow_flag,
    input  logic [31:0] alu_result,
    output logic        regWriteEnable,
    output logic [4:0]  regAddr_1,
    output logic [4:0]  regAddr_2,
    output logic [4:0]  shift_amount,
    output logic [20:0] immediate_const,
    output logic [31:0] npc,
    output logic [3:0]  alu_control,
    output logic        ALU_src,
    output logic        const_src,
    output logic        reg_to_pc,
    output logic        regWrite_select,
    output logic        reg_data,
    output logic        MemRead,
    output logic        MemWrite,
`ifdef CTRL_RETIRE_CNT_EN
    output logic [31:0] retire_count,
`endif
    output logic        halted
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    ctrl_t       ctrl_q, ctrl_d;
    logic        taken_q, taken_d;
    logic [31:0] jr_target_q, jr_target_d;
    logic        req_q, req_d;
    logic [31:0] npc_q, npc_d;
    logic        halted_q, halted_d;

    ctrl_t       dec_ctrl;
    cond_e       dec_cond;
    logic        dec_jr;
    logic        dec_halt;
    logic        cond_hit;
    logic [31:0] seq_pc;

    // Decoding the next IR lets the control outputs be registered with no bubble.
    ctrl_decoder u_decoder (
        .ir      (ir_d),
        .ctrl    (dec_ctrl),
        .cond    (dec_cond),
        .is_jr   (dec_jr),
        .is_halt (dec_halt)
    );

    assign seq_pc = pc_q + PC_STEP;

    always_comb begin
        cond_hit = 1'b0;
        case (dec_cond)
            COND_ALWAYS: cond_hit = 1'b1;
            COND_ZERO:   cond_hit = zero_flag;
            COND_NZERO:  cond_hit = ~zero_flag;
            COND_CARRY:  cond_hit = carry_flag;
            COND_SIGN:   cond_hit = sign_flag;
            COND_OVF:    cond_hit = overflow_flag;
            default:     cond_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        taken_d     = taken_q;
        jr_target_d = jr_target_q;

        case (state_q)
            ST_FETCH: begin
                // req_q gates ack so the idle cycle right after reset cannot latch a word.
                if (imem_ack && req_q) begin
                    ir_d    = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: state_d = dec_halt ? ST_HALT : ST_EXEC;
            ST_EXEC: begin
                taken_d     = cond_hit;
                jr_target_d = alu_result & 32'hFFFF_FFFC;
                state_d     = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (taken_q) begin
                    pc_d = seq_pc + branch_offset(ir_q[IMM_MSB:0]);
                end else if (dec_jr) begin
                    pc_d = jr_target_q;
                end else begin
                    pc_d = seq_pc;
                end
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
        endcase

        ctrl_d = '0;
        if ((state_d == ST_DECODE) || (state_d == ST_EXEC)) begin
            ctrl_d           = dec_ctrl;
            ctrl_d.reg_write = dec_ctrl.reg_write && (state_d == ST_EXEC);
            ctrl_d.mem_write = dec_ctrl.mem_write && (state_d == ST_EXEC);
        end

        req_d    = (state_d == ST_FETCH);
        npc_d    = pc_d + PC_STEP;
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            ctrl_q      <= '0;
            taken_q     <= 1'b0;
            jr_target_q <= '0;
            req_q       <= 1'b0;
            npc_q       <= RESET_PC + PC_STEP;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ctrl_q      <= ctrl_d;
            taken_q     <= taken_d;
            jr_target_q <= jr_target_d;
            req_q       <= req_d;
            npc_q       <= npc_d;
            halted_q    <= halted_d;
        end
    end

`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] retire_count_q, retire_count_d;

    always_comb begin
        retire_count_d = retire_count_q;
        if (state_q == ST_UPDATE) begin
            retire_count_d = retire_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_count_q <= '0;
        end else begin
            retire_count_q <= retire_count_d;
        end
    end

    assign retire_count = retire_count_q;
`endif

    assign imem_addr       = pc_q;
    assign imem_req        = req_q;
    assign npc             = npc_q;
    assign halted          = halted_q;
    assign regWriteEnable  = ctrl_q.reg_write;
    assign MemWrite        = ctrl_q.mem_write;
    assign MemRead         = ctrl_q.mem_read;
    assign regAddr_1       = ctrl_q.reg_addr_1;
    assign regAddr_2       = ctrl_q.reg_addr_2;
    assign shift_amount    = ctrl_q.shift_amount;
    assign immediate_const = ctrl_q.imm;
    assign alu_control     = ctrl_q.alu_control;
    assign ALU_src         = ctrl_q.alu_src;
    assign const_src       = ctrl_q.const_src;
    assign reg_to_pc       = ctrl_q.reg_to_pc;
    assign regWrite_select = ctrl_q.write_sel;
    assign reg_data        = ctrl_q.reg_data;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - table-driven bench for control_sequencer with reset and halt sequences
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        zero_flag, carry_flag, sign_flag, overflow_flag;
    logic [31:0] alu_result;
    logic        regWriteEnable;
    logic [4:0]  regAddr_1, regAddr_2, shift_amount;
    logic [20:0] immediate_const;
    logic [31:0] npc;
    logic [3:0]  alu_control;
    logic        ALU_src, const_src, reg_to_pc, regWrite_select, reg_data;
    logic        MemRead, MemWrite, halted;
`ifdef CTRL_RETIRE_CNT_EN
    logic [31:0] retire_count;
`endif

    logic [9:0]  ctl_act;
    assign ctl_act = {alu_control, ALU_src, const_src, MemRead, reg_data, reg_to_pc, regWrite_select};

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .imem_addr       (imem_addr),
        .imem_req        (imem_req),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .zero_flag       (zero_flag),
        .carry_flag      (carry_flag),
        .sign_flag       (sign_flag),
        .overflow_flag   (overflow_flag),
        .alu_result      (alu_result),
        .regWriteEnable  (regWriteEnable),
        .regAddr_1       (regAddr_1),
        .regAddr_2       (regAddr_2),
        .shift_amount    (shift_amount),
        .immediate_const (immediate_const),
        .npc             (npc),
        .alu_control     (alu_control),
        .ALU_src         (ALU_src),
        .const_src       (const_src),
        .reg_to_pc       (reg_to_pc),
        .regWrite_select (regWrite_select),
        .reg_data        (reg_data),
        .MemRead         (MemRead),
        .MemWrite        (MemWrite),
`ifdef CTRL_RETIRE_CNT_EN
        .retire_count    (retire_count),
`endif
        .halted          (halted)
    );

    // ctl = {alu_control, ALU_src, const_src, MemRead, reg_data, reg_to_pc, regWrite_select}
    typedef struct {
        logic [31:0] instr;
        int          delay;
        logic [3:0]  flags;
        logic [31:0] alu;
        logic [9:0]  ctl;
        logic        we;
        logic        mw;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  sh;
        logic [20:0] imm;
        logic [31:0] next_pc;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input logic [31:0] pc);
        int cyc;
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, pc);
        cyc = 0;
        repeat (v.delay) begin
            @(negedge clk);
            cyc++;
            check("wait_req", imem_req, 1);
        end
        imem_ack   = 1'b1;
        imem_rdata = v.instr;
        @(negedge clk);
        cyc++;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        {zero_flag, carry_flag, sign_flag, overflow_flag} = v.flags;
        alu_result = v.alu;
        check("dec_we", regWriteEnable, 0);
        check("dec_mw", MemWrite, 0);
        check("dec_req", imem_req, 0);
        check("dec_ctl", ctl_act, v.ctl);
        check("dec_ra1", regAddr_1, v.ra1);
        check("dec_ra2", regAddr_2, v.ra2);
        check("dec_shamt", shift_amount, v.sh);
        check("dec_imm", immediate_const, v.imm);
        @(negedge clk);
        cyc++;
        check("exec_we", regWriteEnable, v.we);
        check("exec_mw", MemWrite, v.mw);
        check("exec_ctl", ctl_act, v.ctl);
        check("exec_npc", npc, pc + 32'd4);
        @(negedge clk);
        cyc++;
        check("upd_we", regWriteEnable, 0);
        check("upd_mw", MemWrite, 0);
        @(negedge clk);
        cyc++;
        check("cycles", cyc, v.delay + 4);
        check("next_pc", imem_addr, v.next_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] pc;
        rst = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0; alu_result = 32'h0;
        {zero_flag, carry_flag, sign_flag, overflow_flag} = 4'b0;

        vecs[0]  = '{32'h018E_0002, 0, 4'b0000, 32'h0,         10'b0010_0_0_0_0_0_1, 1'b1, 1'b0, 5'd12, 5'd14, 5'd0,  21'h0E0002, 32'h0000_0004};
        vecs[1]  = '{32'h0022_2809, 0, 4'b0000, 32'h0,         10'b1001_1_1_0_0_0_1, 1'b1, 1'b0, 5'd1,  5'd2,  5'd5,  21'h022809, 32'h0000_0008};
        vecs[2]  = '{32'h8400_0003, 0, 4'b1000, 32'h0,         10'b0000_0_0_0_0_0_0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  21'h000003, 32'h0000_0018};
        vecs[3]  = '{32'h1464_0010, 1, 4'b0000, 32'h0,         10'b0101_1_0_0_0_0_1, 1'b1, 1'b0, 5'd3,  5'd4,  5'd0,  21'h040010, 32'h0000_001C};
        vecs[4]  = '{32'h8400_0003, 0, 4'b0111, 32'h0,         10'b0000_0_0_0_0_0_0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  21'h000003, 32'h0000_0020};
        vecs[5]  = '{32'hC400_0007, 0, 4'b0000, 32'h0,         10'b0000_0_0_0_0_1_0, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  21'h000007, 32'h0000_0040};
        vecs[6]  = '{32'h4045_0008, 0, 4'b0000, 32'h0,         10'b0000_1_0_1_1_0_1, 1'b1, 1'b0, 5'd2,  5'd5,  5'd0,  21'h050008, 32'h0000_0044};
        vecs[7]  = '{32'h4446_0004, 3, 4'b0000, 32'h0,         10'b0000_1_0_0_0_0_0, 1'b0, 1'b1, 5'd2,  5'd6,  5'd0,  21'h060004, 32'h0000_0048};
        vecs[8]  = '{32'h881F_FFFE, 0, 4'b0000, 32'h0,         10'b0000_0_0_0_0_0_0, 1'b0, 1'b0, 5'd0,  5'd31, 5'd31, 21'h1FFFFE, 32'h0000_0044};
        vecs[9]  = '{32'h8C00_0010, 0, 4'b1011, 32'h0,         10'b0000_0_0_0_0_0_0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  21'h000010, 32'h0000_0048};
        vecs[10] = '{32'h9000_0001, 0, 4'b0010, 32'h0,         10'b0000_0_0_0_0_0_0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  21'h000001, 32'h0000_0050};
        vecs[11] = '{32'h9400_0004, 0, 4'b0001, 32'h0,         10'b0000_0_0_0_0_0_0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  21'h000004, 32'h0000_0064};
        vecs[12] = '{32'h8000_003F, 2, 4'b0000, 32'h0,         10'b0000_0_0_0_0_0_0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  21'h00003F, 32'h0000_0164};
        vecs[13] = '{32'hC000_0000, 0, 4'b0000, 32'h0000_0027, 10'b0000_0_0_0_0_0_0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  21'h000000, 32'h0000_0024};
        vecs[14] = '{32'hF800_0000, 0, 4'b0000, 32'hDEAD_BEE0, 10'b0000_0_0_0_0_0_0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  21'h000000, 32'h0000_0028};
        vecs[15] = '{32'h3FE0_1234, 0, 4'b0000, 32'h0,         10'b1111_1_0_0_0_0_1, 1'b1, 1'b0, 5'd31, 5'd0,  5'd2,  21'h001234, 32'h0000_002C};
        vecs[16] = '{32'hC000_0000, 0, 4'b0000, 32'hFFFF_FFFE, 10'b0000_0_0_0_0_0_0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  21'h000000, 32'hFFFF_FFFC};
        vecs[17] = '{32'h0000_0001, 0, 4'b0000, 32'h0,         10'b0001_0_0_0_0_0_1, 1'b1, 1'b0, 5'd0,  5'd0,  5'd0,  21'h000001, 32'h0000_0000};
        vecs[18] = '{32'h8000_0004, 0, 4'b0000, 32'h0,         10'b0000_0_0_0_0_0_0, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  21'h000004, 32'h0000_0014};

        @(negedge clk);
        @(negedge clk);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_npc", npc, 32'h4);
        check("rst_halted", halted, 0);
        check("rst_ctl", ctl_act, 0);
        rst = 1'b0;
        @(negedge clk);

        pc = 32'h0;
        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], pc);
            pc = vecs[i].next_pc;
`ifdef CTRL_RETIRE_CNT_EN
            check("retire_count", retire_count, i + 1);
`endif
        end

        // Reset pulse in the middle of a stalled fetch, with ack and a word present.
        check("pre_rst_addr", imem_addr, 32'h14);
        repeat (2) @(negedge clk);
        check("pre_rst_req", imem_req, 1);
        rst        = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h018E_0002;
        @(negedge clk);
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_npc", npc, 32'h4);
        check("mid_rst_we", regWriteEnable, 0);
        check("mid_rst_ra1", regAddr_1, 0);
`ifdef CTRL_RETIRE_CNT_EN
        check("mid_rst_retire", retire_count, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("rel_req", imem_req, 1);
        check("rel_addr", imem_addr, 32'h0);
        check("rel_ra1", regAddr_1, 0);

        // HLT, then ack held high to confirm no further fetches.
        imem_rdata = 32'hFC00_0000;
        @(negedge clk);
        check("hlt_dec_req", imem_req, 0);
        check("hlt_dec_halted", halted, 0);
        @(negedge clk);
        check("hlt_halted", halted, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("halt_req", imem_req, 0);
            check("halt_halted", halted, 1);
            check("halt_we", regWriteEnable, 0);
            check("halt_mw", MemWrite, 0);
        end
        check("halt_addr", imem_addr, 32'h0);
`ifdef CTRL_RETIRE_CNT_EN
        check("halt_retire", retire_count, 0);
`endif
        imem_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
